// File: rtl/ram_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_bist_ctrl
// Purpose  : Built-in self-test master for a single-port RAM. Writes a
//            selectable pattern to every address, reads everything back,
//            compares against the expected pattern and reports statistics.
// Ports    : clk, rst (sync, active-high)
//            start, pattern_sel[1:0]    run request / pattern choice
//            busy, done, pass           run status
//            err_count, first_err_addr  mismatch statistics
//            ram_wr, ram_rd, ram_add, ram_data_in, ram_data_out  RAM port
// Options  : RAM_BIST_MARCH_EN - when defined, a second write/read pass with
//            the inverted pattern follows the first before DONE.
// Revision : 1.0 - initial release
// ============================================================================
module ram_bist_ctrl #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        pattern_sel,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W+1:0] err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              ram_wr,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_add,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W+1:0] ERR_ONE   = {{(ADDR_W+1){1'b0}}, 1'b1};
  localparam logic [ADDR_W+1:0] ERR_MAX   = '1;

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic [1:0]          pat;        // pattern latched at start
  logic                inv;        // second (inverted) pass in march mode
  logic                cmp_valid;  // ram_data_out holds a word to compare
  logic [ADDR_W-1:0]   cmp_addr;   // address that word was read from
  logic [DATA_W-1:0]   exp_word;
  logic                mismatch;

  // Pattern generator: address is zero-extended or truncated to DATA_W.
  function automatic logic [DATA_W-1:0] pattern_word(
    input logic [1:0]        sel,
    input logic [ADDR_W-1:0] a,
    input logic              invert
  );
    logic [DATA_W-1:0] w;
    w = '0;
    case (sel)
      2'b00:   w = DATA_W'(a);
      2'b01:   w = ~DATA_W'(a);
      2'b10:   for (int i = 0; i < DATA_W; i++) w[i] = a[0] ^ (i % 2 == 0);
      default: w = '1;
    endcase
    return invert ? ~w : w;
  endfunction

  assign exp_word = pattern_word(pat, cmp_addr, inv);
  assign mismatch = cmp_valid && (ram_data_out != exp_word);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      addr           <= '0;
      pat            <= '0;
      inv            <= 1'b0;
      cmp_valid      <= 1'b0;
      cmp_addr       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      ram_wr         <= 1'b0;
      ram_rd         <= 1'b0;
      ram_add        <= '0;
      ram_data_in    <= '0;
    end else begin
      // Read data arrives one cycle after ram_rd, so delay the address too.
      cmp_valid <= ram_rd;
      cmp_addr  <= ram_add;

      if (mismatch) begin
        if (err_count == '0) first_err_addr <= cmp_addr;
        if (err_count != ERR_MAX) err_count <= err_count + ERR_ONE;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state          <= S_WRITE;
            pat            <= pattern_sel;
            inv            <= 1'b0;
            addr           <= '0;
            busy           <= 1'b1;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            ram_wr         <= 1'b1;
            ram_add        <= '0;
            ram_data_in    <= pattern_word(pattern_sel, '0, 1'b0);
          end
        end

        S_WRITE: begin
          if (addr == ADDR_LAST) begin
            state       <= S_READ;
            addr        <= '0;
            ram_wr      <= 1'b0;
            ram_rd      <= 1'b1;
            ram_add     <= '0;
            ram_data_in <= '0;
          end else begin
            addr        <= addr + ADDR_ONE;
            ram_add     <= addr + ADDR_ONE;
            ram_data_in <= pattern_word(pat, addr + ADDR_ONE, inv);
          end
        end

        S_READ: begin
          if (addr == ADDR_LAST) begin
            state   <= S_DRAIN;
            addr    <= '0;
            ram_rd  <= 1'b0;
            ram_add <= '0;
          end else begin
            addr    <= addr + ADDR_ONE;
            ram_add <= addr + ADDR_ONE;
          end
        end

        // The last read word is compared on this edge, so the final
        // verdict must include the mismatch being counted right now.
        S_DRAIN: begin
`ifdef RAM_BIST_MARCH_EN
          if (!inv) begin
            state       <= S_WRITE;
            inv         <= 1'b1;
            addr        <= '0;
            ram_wr      <= 1'b1;
            ram_add     <= '0;
            ram_data_in <= pattern_word(pat, '0, 1'b1);
          end else begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch;
          end
`else
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_count == '0) && !mismatch;
`endif
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end

        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          ram_wr <= 1'b0;
          ram_rd <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_bist_ctrl
// Purpose  : Directed self-checking bench for ram_bist_ctrl with a small
//            behavioural RAM that can inject read faults.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_bist_ctrl;

`ifdef RAM_BIST_MARCH_EN
  localparam int RUN_CYC = 35;
  localparam int WR_TOT  = 16;
`else
  localparam int RUN_CYC = 18;
  localparam int WR_TOT  = 8;
`endif
  localparam int CYC_LIMIT = 100;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] pattern_sel;
  logic       busy, done, pass;
  logic [4:0] err_count;
  logic [2:0] first_err_addr;
  logic       ram_wr, ram_rd;
  logic [2:0] ram_add;
  logic [3:0] ram_data_in;
  logic [3:0] ram_data_out;

  int n_assert = 0;
  int n_fail   = 0;
  int fault_mode = 0;  // 0 clean, 1 bit0 stuck-0 at addr 5, 2 all bits stuck-0

  ram_bist_ctrl #(.DATA_W(4), .ADDR_W(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .pattern_sel    (pattern_sel),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .ram_wr         (ram_wr),
    .ram_rd         (ram_rd),
    .ram_add        (ram_add),
    .ram_data_in    (ram_data_in),
    .ram_data_out   (ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM: write on posedge, registered read.
  logic [3:0] mem [8];
  logic [3:0] rq;
  logic [2:0] rq_addr;

  always_ff @(posedge clk) begin
    if (ram_wr) mem[ram_add] <= ram_data_in;
    if (ram_rd) begin
      rq      <= mem[ram_add];
      rq_addr <= ram_add;
    end
  end

  always_comb begin
    ram_data_out = rq;
    if (fault_mode == 1 && rq_addr == 3'd5) ram_data_out = rq & 4'b1110;
    else if (fault_mode == 2)               ram_data_out = 4'b0000;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete run; pattern_sel is scrambled after acceptance to confirm
  // the latched copy is used.
  task automatic do_run(input string name, input logic [1:0] sel, input int fault,
                        input logic [31:0] exp_data, input logic [4:0] exp_err,
                        input logic [2:0] exp_first, input logic exp_pass);
    int          cyc, done_cyc, wr_n, rd_n;
    logic        both;
    logic [31:0] wdat;
    logic [23:0] wadr;
    fault_mode = fault;
    @(negedge clk);
    start       = 1'b1;
    pattern_sel = sel;
    @(negedge clk);
    start       = 1'b0;
    pattern_sel = ~sel;
    cyc = 1; done_cyc = 0; wr_n = 0; rd_n = 0; both = 1'b0; wdat = '0; wadr = '0;
    while (done_cyc == 0 && cyc < CYC_LIMIT) begin
      if (ram_wr && ram_rd) both = 1'b1;
      if (ram_wr) begin
        if (wr_n < 8) begin
          wdat = {wdat[27:0], ram_data_in};
          wadr = {wadr[20:0], ram_add};
        end
        wr_n++;
      end
      if (ram_rd) rd_n++;
      if (done) done_cyc = cyc;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check({name, "_done_cycle"}, done_cyc, RUN_CYC);
    check({name, "_busy_at_done"}, busy, 0);
    check({name, "_pass"}, pass, exp_pass);
    check({name, "_err_count"}, err_count, exp_err);
    check({name, "_first_err"}, first_err_addr, exp_first);
    check({name, "_wr_data"}, wdat, exp_data);
    check({name, "_wr_addr"}, wadr, 24'o01234567);
    check({name, "_wr_cycles"}, wr_n, WR_TOT);
    check({name, "_rd_cycles"}, rd_n, WR_TOT);
    check({name, "_wr_rd_overlap"}, both, 0);
    @(negedge clk);
    check({name, "_done_pulse_end"}, done, 0);
    check({name, "_pass_hold"}, pass, exp_pass);
    check({name, "_err_hold"}, err_count, exp_err);
    check({name, "_idle_add"}, ram_add, 0);
  endtask

  initial begin
    int npulse, d1, d2;
    rst = 1'b1; start = 1'b0; pattern_sel = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_first", first_err_addr, 0);
    check("rst_wr", ram_wr, 0);
    check("rst_rd", ram_rd, 0);
    check("rst_add", ram_add, 0);
    check("rst_din", ram_data_in, 0);
    rst = 1'b0;

    do_run("addr_clean",  2'b00, 0, 32'h01234567, 5'd0, 3'd0, 1'b1);
    do_run("addr_stuck5", 2'b00, 1, 32'h01234567, 5'd1, 3'd5, 1'b0);
    do_run("ones_stuck",  2'b11, 2, 32'hFFFFFFFF, 5'd8, 3'd0, 1'b0);
    do_run("chk_clean",   2'b10, 0, 32'h5A5A5A5A, 5'd0, 3'd0, 1'b1);
    do_run("inv_clean",   2'b01, 0, 32'hFEDCBA98, 5'd0, 3'd0, 1'b1);

    // start held high: one run per IDLE visit, nothing accepted while busy/DONE.
    fault_mode = 0;
    @(negedge clk);
    start = 1'b1; pattern_sel = 2'b00;
    @(negedge clk);
    npulse = 0; d1 = 0; d2 = 0;
    for (int cyc = 1; cyc <= 2 * RUN_CYC + 3; cyc++) begin
      if (done) begin
        npulse++;
        if (npulse == 1) d1 = cyc;
        else if (npulse == 2) d2 = cyc;
      end
      if (cyc == RUN_CYC + 1) check("held_idle_busy", busy, 0);
      if (cyc == RUN_CYC + 2) check("held_restart_wr", ram_wr, 1);
      @(negedge clk);
    end
    check("held_pulses", npulse, 2);
    check("held_done1", d1, RUN_CYC);
    check("held_done2", d2, 2 * RUN_CYC + 1);
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_write_busy", busy, 0);
    check("rst_in_write_wr", ram_wr, 0);

    // Reset at the third READ cycle with errors already counted.
    fault_mode = 2;
    @(negedge clk);
    start = 1'b1; pattern_sel = 2'b11;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst_rd", ram_rd, 1);
    check("pre_rst_add", ram_add, 2);
    check("pre_rst_err", err_count, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_busy", busy, 0);
    check("post_rst_rd", ram_rd, 0);
    check("post_rst_err", err_count, 0);
    check("post_rst_done", done, 0);

    do_run("after_rst", 2'b00, 0, 32'h01234567, 5'd0, 3'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
